// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the pushbutton conditioner.
//   - rpt_state_e : per-channel auto-repeat state (IDLE / DELAY / REPEAT)
//   - DEF_*       : default timing in 25 MHz clock cycles
//   - BTN_*       : board channel indices into the CHANNELS-wide vectors
//   - timer_width : width of the repeat timer for a given delay/period pair
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DEF_CHANNELS      = 5;
  localparam int DEF_STABLE_CYCLES = 1_000_000;  // 40 ms
  localparam int DEF_REPEAT_DELAY  = 12_500_000; // 500 ms
  localparam int DEF_REPEAT_PERIOD = 2_500_000;  // 100 ms

  localparam int BTN_CHOP  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 4;

  // The timer only ever reaches max(delay, period)-1. Never return 0 so a
  // 1-cycle delay/period still gets a legal one-bit register.
  function automatic int timer_width(input int dly, input int per);
    int m;
    m = (dly > per) ? dly : per;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one pushbutton channel.
//   Optional two-flop synchroniser (BTN_SYNC_EN), saturating-counter
//   debouncer, press/release edge pulses and a hold-to-repeat FSM.
// Ports:
//   clock_in     : system clock
//   reset_in     : synchronous, active-high reset
//   noisy_in     : raw button level
//   repeat_en_in : auto-repeat enable
//   clean_out    : debounced level
//   press_out    : 1-cycle pulse when clean_out rises
//   release_out  : 1-cycle pulse when clean_out falls
//   repeat_out   : press pulse plus auto-repeat pulses while held
// Config macro: BTN_SYNC_EN adds the synchroniser (+2 cycles latency).
module button_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic noisy_in,
  input  logic repeat_en_in,
  output logic clean_out,
  output logic press_out,
  output logic release_out,
  output logic repeat_out
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  logic samp;

`ifdef BTN_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = noisy_in;
    sync2_d = sync1_q;
  end

  // Both stages load the raw input in reset so the debouncer starts aligned
  // with the pins and no spurious edge walks through the pipe afterwards.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      sync1_q <= noisy_in;
      sync2_q <= noisy_in;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = noisy_in;
`endif

  // ---------------- debounce + edge detect ----------------
  logic          new_input_q, new_input_d;
  logic [CW-1:0] count_q, count_d;
  logic          clean_q, clean_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    new_input_d = new_input_q;
    count_d     = count_q;
    clean_d     = clean_q;
    if (samp != new_input_q) begin
      new_input_d = samp;
      count_d     = '0;
    end else if (count_q == CNT_MAX) begin
      clean_d = new_input_q;       // counter saturates here
    end else begin
      count_d = count_q + 1'b1;
    end
    // Pulses are registered on the same edge that moves clean_q.
    press_d   =  clean_d & ~clean_q;
    release_d = ~clean_d &  clean_q;
  end

  // In reset the debounced level is taken straight from the pins (the
  // synchroniser stages hold the same value), so reset never creates an edge.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      new_input_q <= noisy_in;
      clean_q     <= noisy_in;
      count_q     <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      new_input_q <= new_input_d;
      clean_q     <= clean_d;
      count_q     <= count_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  // ---------------- repeat FSM ----------------
  rpt_state_e    state_q;
  logic [TW-1:0] timer_q;
  logic          repeat_q;

  // A release or a dropped enable beats a timer expiry in the same cycle.
  // DELAY/REPEAT imply clean_q==1, so press_d can only occur in IDLE.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_d) begin
            repeat_q <= 1'b1;
            if (repeat_en_in) begin
              timer_q <= '0;
              state_q <= DELAY;
            end
          end
        end
        DELAY: begin
          if (release_d || !repeat_en_in) begin
            state_q <= IDLE;
          end else if (timer_q == DLY_LAST) begin
            repeat_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= REPEAT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        REPEAT: begin
          if (release_d || !repeat_en_in) begin
            state_q <= IDLE;
          end else if (timer_q == PER_LAST) begin
            repeat_q <= 1'b1;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clean_out   = clean_q;
  assign press_out   = press_q;
  assign release_out = release_q;
  assign repeat_out  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: CHANNELS independent pushbutton conditioners.
// Ports (all CHANNELS wide except clock/reset):
//   clock_in, reset_in (synchronous, active-high)
//   noisy_in     : raw button levels
//   repeat_en_in : per-channel auto-repeat enable
//   clean_out    : debounced levels
//   press_out    : 1-cycle pulse on debounced rise
//   release_out  : 1-cycle pulse on debounced fall
//   repeat_out   : press pulse plus hold-to-repeat pulses
// Config macro: BTN_SYNC_EN inserts a two-flop synchroniser per channel.
// Channel indices for the board buttons are in btn_pkg (BTN_CHOP..BTN_DOWN).
module button_conditioner
  import btn_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic                clock_in,
  input  logic                reset_in,
  input  logic [CHANNELS-1:0] noisy_in,
  input  logic [CHANNELS-1:0] repeat_en_in,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] press_out,
  output logic [CHANNELS-1:0] release_out,
  output logic [CHANNELS-1:0] repeat_out
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clock_in     (clock_in),
      .reset_in     (reset_in),
      .noisy_in     (noisy_in[g]),
      .repeat_en_in (repeat_en_in[g]),
      .clean_out    (clean_out[g]),
      .press_out    (press_out[g]),
      .release_out  (release_out[g]),
      .repeat_out   (repeat_out[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with STABLE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, no synchroniser. Inputs change 1 time unit after a rising
// edge k, so they are first sampled at edge k+1 and a debounced change
// appears at edge k+6. Expected pulse events are pushed when stimulus is
// driven; a negedge monitor logs every observed pulse, and the two lists are
// compared at checkpoints.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int CH = 5;
  localparam int K_PRESS = 0, K_REL = 1, K_REP = 2;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic [CH-1:0] noisy_in = '0;
  logic [CH-1:0] repeat_en_in = '0;
  logic [CH-1:0] clean_out, press_out, release_out, repeat_out;

  button_conditioner #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .noisy_in     (noisy_in),
    .repeat_en_in (repeat_en_in),
    .clean_out    (clean_out),
    .press_out    (press_out),
    .release_out  (release_out),
    .repeat_out   (repeat_out)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int exp_q[$];
  int obs_q[$];
  bit mon_en = 1'b0;

  function automatic int ev(input int c, input int kind, input int ch);
    return c * 64 + kind * 8 + ch;
  endfunction

  always @(negedge clock_in) begin
    if (mon_en) begin
      for (int c = 0; c < CH; c++) begin
        if (press_out[c])   obs_q.push_back(ev(cyc, K_PRESS, c));
        if (release_out[c]) obs_q.push_back(ev(cyc, K_REL, c));
        if (repeat_out[c])  obs_q.push_back(ev(cyc, K_REP, c));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_in);
    #1;
  endtask

  task automatic tick_to(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_events(input string name);
    int g;
    exp_q.sort();
    obs_q.sort();
    checks++;
    if (exp_q.size() != obs_q.size()) begin
      failures++;
      $display("FAIL %s event count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      g = (i < obs_q.size()) ? obs_q[i] : -1;
      if (g != exp_q[i]) begin
        failures++;
        $display("FAIL %s event %0d: got cyc=%0d kind=%0d ch=%0d want cyc=%0d kind=%0d ch=%0d",
                 name, i, g / 64, (g % 64) / 8, g % 8,
                 exp_q[i] / 64, (exp_q[i] % 64) / 8, exp_q[i] % 8);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  typedef struct {
    logic [CH-1:0] noisy;
    logic [CH-1:0] exp_clean;
  } rst_vec_t;

  rst_vec_t tbl[5];

  initial begin
    int k, p;

    tbl[0] = '{noisy: 5'b11010, exp_clean: 5'b11010};
    tbl[1] = '{noisy: 5'b00000, exp_clean: 5'b00000};
    tbl[2] = '{noisy: 5'b11111, exp_clean: 5'b11111};
    tbl[3] = '{noisy: 5'b01001, exp_clean: 5'b01001};
    tbl[4] = '{noisy: 5'b00101, exp_clean: 5'b00101};

    // Reset loads clean_out from the pins, whatever they are, with no pulses.
    for (int i = 0; i < 5; i++) begin
      reset_in = 1'b1;
      noisy_in = tbl[i].noisy;
      tick(2);
      chk("reset_clean", 32'(clean_out), 32'(tbl[i].exp_clean));
      chk("reset_pulses", 32'({press_out, release_out, repeat_out}), 32'd0);
    end

    reset_in = 1'b0;
    mon_en   = 1'b1;
    tick(1);
    chk("clean_after_reset", 32'(clean_out), 32'h05);
    tick(20);
    chk("clean_quiet", 32'(clean_out), 32'h05);
    check_events("quiet_after_reset");

    // Single clean step on channel 1: exact latency and one-cycle pulses.
    k = cyc;
    noisy_in[BTN_LEFT] = 1'b1;
    exp_q.push_back(ev(k + 6, K_PRESS, BTN_LEFT));
    exp_q.push_back(ev(k + 6, K_REP, BTN_LEFT));
    tick(5);
    chk("step_clean_before", 32'(clean_out[BTN_LEFT]), 32'd0);
    tick(1);
    chk("step_clean_after", 32'(clean_out[BTN_LEFT]), 32'd1);
    chk("step_press_hi", 32'(press_out[BTN_LEFT]), 32'd1);
    tick(1);
    chk("step_press_lo", 32'(press_out[BTN_LEFT]), 32'd0);
    tick(3);
    k = cyc;
    noisy_in[BTN_LEFT] = 1'b0;
    exp_q.push_back(ev(k + 6, K_REL, BTN_LEFT));
    tick(10);
    check_events("step_ch1");

    // Bounce on channel 0: drop it first, then toggle every 2 cycles.
    k = cyc;
    noisy_in[BTN_CHOP] = 1'b0;
    exp_q.push_back(ev(k + 6, K_REL, BTN_CHOP));
    tick(10);
    for (int i = 0; i <= 10; i++) begin
      noisy_in[BTN_CHOP] = ~noisy_in[BTN_CHOP];
      if (i < 10) tick(2);
    end
    k = cyc;
    exp_q.push_back(ev(k + 6, K_PRESS, BTN_CHOP));
    exp_q.push_back(ev(k + 6, K_REP, BTN_CHOP));
    tick(12);
    chk("bounce_clean", 32'(clean_out[BTN_CHOP]), 32'd1);
    check_events("bounce_ch0");

    // Hold channel 3 with repeat enabled; release lands at P+30.
    repeat_en_in[BTN_UP] = 1'b1;
    k = cyc;
    noisy_in[BTN_UP] = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_UP));
    exp_q.push_back(ev(p, K_REP, BTN_UP));
    exp_q.push_back(ev(p + 10, K_REP, BTN_UP));
    for (int o = 13; o <= 28; o += 3) exp_q.push_back(ev(p + o, K_REP, BTN_UP));
    tick_to(p + 24);
    noisy_in[BTN_UP] = 1'b0;
    exp_q.push_back(ev(p + 30, K_REL, BTN_UP));
    tick(15);
    check_events("repeat_ch3");

    // Same hold with repeat disabled: only the press-time pulse.
    repeat_en_in[BTN_UP] = 1'b0;
    k = cyc;
    noisy_in[BTN_UP] = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_UP));
    exp_q.push_back(ev(p, K_REP, BTN_UP));
    tick_to(p + 24);
    noisy_in[BTN_UP] = 1'b0;
    exp_q.push_back(ev(p + 30, K_REL, BTN_UP));
    tick(15);
    check_events("norepeat_ch3");

    // Channels 2 and 4 pressed together, only channel 2 repeating.
    k = cyc;
    noisy_in[BTN_RIGHT] = 1'b0;
    exp_q.push_back(ev(k + 6, K_REL, BTN_RIGHT));
    tick(10);
    repeat_en_in[BTN_RIGHT] = 1'b1;
    repeat_en_in[BTN_DOWN]  = 1'b0;
    k = cyc;
    noisy_in[BTN_RIGHT] = 1'b1;
    noisy_in[BTN_DOWN]  = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_RIGHT));
    exp_q.push_back(ev(p, K_PRESS, BTN_DOWN));
    exp_q.push_back(ev(p, K_REP, BTN_RIGHT));
    exp_q.push_back(ev(p, K_REP, BTN_DOWN));
    exp_q.push_back(ev(p + 10, K_REP, BTN_RIGHT));
    exp_q.push_back(ev(p + 13, K_REP, BTN_RIGHT));
    exp_q.push_back(ev(p + 16, K_REP, BTN_RIGHT));
    tick_to(p + 11);
    noisy_in[BTN_RIGHT] = 1'b0;
    noisy_in[BTN_DOWN]  = 1'b0;
    exp_q.push_back(ev(p + 17, K_REL, BTN_RIGHT));
    exp_q.push_back(ev(p + 17, K_REL, BTN_DOWN));
    tick(12);
    check_events("dual_ch2_ch4");
    repeat_en_in[BTN_RIGHT] = 1'b0;

    // Enable raised mid-hold (ch1) does nothing; enable dropped (ch4) stops.
    repeat_en_in[BTN_LEFT] = 1'b0;
    repeat_en_in[BTN_DOWN] = 1'b1;
    k = cyc;
    noisy_in[BTN_LEFT] = 1'b1;
    noisy_in[BTN_DOWN] = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_LEFT));
    exp_q.push_back(ev(p, K_PRESS, BTN_DOWN));
    exp_q.push_back(ev(p, K_REP, BTN_LEFT));
    exp_q.push_back(ev(p, K_REP, BTN_DOWN));
    tick_to(p + 2);
    repeat_en_in[BTN_LEFT] = 1'b1;
    repeat_en_in[BTN_DOWN] = 1'b0;
    tick_to(p + 20);
    noisy_in[BTN_LEFT] = 1'b0;
    noisy_in[BTN_DOWN] = 1'b0;
    exp_q.push_back(ev(p + 26, K_REL, BTN_LEFT));
    exp_q.push_back(ev(p + 26, K_REL, BTN_DOWN));
    tick(12);
    check_events("enable_change");
    repeat_en_in[BTN_LEFT] = 1'b0;

    // Reset at offset 14 of a repeating hold on channel 3.
    repeat_en_in[BTN_UP] = 1'b1;
    k = cyc;
    noisy_in[BTN_UP] = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_UP));
    exp_q.push_back(ev(p, K_REP, BTN_UP));
    exp_q.push_back(ev(p + 10, K_REP, BTN_UP));
    exp_q.push_back(ev(p + 13, K_REP, BTN_UP));
    tick_to(p + 13);
    reset_in = 1'b1;
    tick(1);
    chk("midreset_clean", 32'(clean_out[BTN_UP]), 32'd1);
    chk("midreset_pulses", 32'({press_out, release_out, repeat_out}), 32'd0);
    reset_in = 1'b0;
    tick(20);
    chk("postreset_clean", 32'(clean_out), 32'h09);
    check_events("reset_mid_hold");

    k = cyc;
    noisy_in[BTN_UP] = 1'b0;
    exp_q.push_back(ev(k + 6, K_REL, BTN_UP));
    tick(10);
    k = cyc;
    noisy_in[BTN_UP] = 1'b1;
    p = k + 6;
    exp_q.push_back(ev(p, K_PRESS, BTN_UP));
    exp_q.push_back(ev(p, K_REP, BTN_UP));
    tick_to(p + 2);
    noisy_in[BTN_UP] = 1'b0;
    exp_q.push_back(ev(p + 8, K_REL, BTN_UP));
    tick(12);
    check_events("repress_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
